// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single data-memory port between the pipeline memory stage and
// the host/debug port. Core has priority; a bounded wait forces a one-cycle host grant.
module dmem_port_arbiter #(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned HOST_MAX_WAIT = 4,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             core_req_i,
  input  logic             core_we_i,
  input  logic [XLEN-1:0]  core_addr_i,
  input  logic [XLEN-1:0]  core_wdata_i,
  output logic [XLEN-1:0]  core_rdata_o,
  output logic             core_stall_o,
  input  logic             host_req_i,
  input  logic             host_we_i,
  input  logic [XLEN-1:0]  host_addr_i,
  input  logic [XLEN-1:0]  host_wdata_i,
  output logic             host_gnt_o,
  output logic             host_rvalid_o,
  output logic [XLEN-1:0]  host_rdata_o,
  output logic [XLEN-1:0]  mem_addr_o,
  output logic [XLEN-1:0]  mem_wdata_o,
  output logic             mem_we_o,
  input  logic [XLEN-1:0]  mem_rdata_i,
  output logic [CNT_W-1:0] conflict_cnt_o
);

  localparam int unsigned WAIT_W = (HOST_MAX_WAIT == 0) ? 1 : $clog2(HOST_MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(HOST_MAX_WAIT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              host_sel;

  always_comb begin
    host_sel = host_req_i & (~core_req_i | (wait_cnt == WAIT_MAX));
  end

  always_comb begin
    host_gnt_o    = host_sel;
    core_stall_o  = host_sel & core_req_i;
    core_rdata_o  = mem_rdata_i;
    host_rvalid_o = (state == ST_RESP);
    if (host_sel) begin
      mem_addr_o  = host_addr_i;
      mem_wdata_o = host_wdata_i;
      mem_we_o    = host_we_i;
    end else begin
      mem_addr_o  = core_addr_i;
      mem_wdata_o = core_wdata_i;
      mem_we_o    = core_we_i & core_req_i;
    end
  end

  // wait_cnt only advances while the host is blocked, so it saturates at WAIT_MAX
  // by construction: reaching WAIT_MAX forces host_sel on the next request cycle.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state          <= ST_IDLE;
      wait_cnt       <= '0;
      host_rdata_o   <= '0;
      conflict_cnt_o <= '0;
    end else begin
      wait_cnt <= (host_req_i & ~host_sel) ? wait_cnt + 1'b1 : '0;

      if (host_sel & ~host_we_i) begin
        state        <= ST_RESP;
        host_rdata_o <= mem_rdata_i;
      end else if (host_sel) begin
        state <= ST_IDLE;
      end else if (host_req_i) begin
        state <= ST_WAIT;
      end else begin
        state <= ST_IDLE;
      end

      if (core_req_i & host_req_i & ~(&conflict_cnt_o)) begin
        conflict_cnt_o <= conflict_cnt_o + 1'b1;
      end
    end
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single data-memory port between two requesters: the pipeline's memory stage (core) and the external host/debug access port (addr_i/data_o path, optionally writing).
- Core has default priority. A bounded-wait counter guarantees host service by stalling the pipeline for one cycle when the host has waited too long.
- Sits between the execute/memory pipeline register outputs, the host port, and data_memory. Its core_stall_o output feeds the hazard unit, which freezes F, D, E and M.

Parameters:
- XLEN, 32, data/address width.
- HOST_MAX_WAIT, 4, cycles the host may be blocked by core traffic before a forced grant. 0 means the host always wins.
- CNT_W, 16, width of the saturating conflict counter.

Ports:
- clk_i  in  1  system clock
- rstn_i  in  1  reset, asynchronous, active-low
- core_req_i  in  1  memory-stage access valid (load or store in M)
- core_we_i  in  1  core write enable (MemWrite_m)
- core_addr_i  in  XLEN  core byte address (ALUResult_m)
- core_wdata_i  in  XLEN  core store data (WriteData_m)
- core_rdata_o  out  XLEN  core load data, combinational from mem_rdata_i
- core_stall_o  out  1  pipeline stall request, to hazard unit
- host_req_i  in  1  host access request; must be held with stable fields until host_gnt_o
- host_we_i  in  1  host write enable
- host_addr_i  in  XLEN  host byte address
- host_wdata_i  in  XLEN  host write data
- host_gnt_o  out  1  host access performed this cycle
- host_rvalid_o  out  1  host read data valid, one-cycle pulse
- host_rdata_o  out  XLEN  registered host read data
- mem_addr_o  out  XLEN  to data_memory A
- mem_wdata_o  out  XLEN  to data_memory write_data
- mem_we_o  out  1  to data_memory write_enable
- mem_rdata_i  in  XLEN  from data_memory read_data (combinational read)
- conflict_cnt_o  out  CNT_W  saturating count of cycles with both requests asserted

Behaviour:
- Reset (rstn_i=0, asynchronous): wait_cnt=0, host_rvalid_o=0, host_rdata_o=0, conflict_cnt_o=0, FSM=IDLE. Any pending host transaction is dropped; the host must re-request. Combinational outputs follow their inputs.
- Grant equation, per cycle: host_sel = host_req_i & (!core_req_i | wait_cnt == HOST_MAX_WAIT).
- host_gnt_o = host_sel, asserted in the same cycle.
- core_stall_o = host_sel & core_req_i. It is asserted only on a forced grant.
- Mux: if host_sel, mem_* are driven from the host_* inputs and mem_we_o = host_we_i. Otherwise mem_* are driven from the core_* inputs and mem_we_o = core_we_i & core_req_i.
- A write commits at the rising edge closing the grant cycle.
- core_rdata_o = mem_rdata_i at all times. The core ignores it while stalled.
- wait_cnt, width clog2(HOST_MAX_WAIT+1) min 1:
  - reset to 0 on host_sel;
  - incremented when host_req_i & !host_sel;
  - held at 0 when host_req_i=0.
  - It never exceeds HOST_MAX_WAIT.
- FSM states:
  - IDLE to WAIT on host_req_i & !host_sel.
  - IDLE or WAIT to RESP on host_sel & !host_we_i.
  - IDLE or WAIT to IDLE on host_sel & host_we_i.
  - RESP to IDLE unconditionally, or to WAIT/RESP per the same rules if a new host_req_i is present.
  - In RESP: host_rvalid_o=1 and host_rdata_o holds mem_rdata_i captured at the grant edge. host_rdata_o holds its value until the next read grant.
  - Writes produce no rvalid.
- Back-to-back host reads are allowed: gnt in cycle N and N+1 give rvalid in N+1 and N+2.
- Stall interaction: a forced grant freezes M, so core_req_i stays asserted in cycle N+1. Because wait_cnt=0 there, the core is guaranteed service in N+1. Under continuous contention the host gets exactly 1 of every HOST_MAX_WAIT+1 cycles.
- With HOST_MAX_WAIT=0, every host request is granted immediately, with a stall if the core is active.
- conflict_cnt_o increments when core_req_i & host_req_i, saturating at all-ones.
- Address/data are not checked for alignment or range; data_memory owns that behaviour.

Test Plan:
- Idle core, host write 0x40 <- 0xDEADBEEF, then host read 0x40: gnt in the request cycle; rvalid one cycle after the read grant with host_rdata_o=0xDEADBEEF; core_stall_o=0 throughout.
- Core store 0x10 <- 0x12345678 with no host request: mem_we_o=1, mem_addr_o=0x10, host_gnt_o=0. A later host read of 0x10 returns 0x12345678.
- HOST_MAX_WAIT=4, core_req_i held 1, host read held: no gnt for 4 cycles; gnt and core_stall_o=1 in the 5th cycle; core served in the 6th; pattern repeats every 5 cycles; conflict_cnt_o increments every cycle.
- HOST_MAX_WAIT=0, simultaneous core load and host write: host wins with core_stall_o=1; core wins the next cycle. The core load of the same address returns the host-written value.
- Assert rstn_i=0 mid-cycle while in WAIT with wait_cnt=3: outputs clear immediately without waiting for a clock edge. After release with host_req_i still high, the wait count restarts from 0.
- Force conflict_cnt_o near saturation (CNT_W=4, 20 contention cycles): the counter stops at 0xF.
